lc4_fetch_buffer: RTL
=====================

Name: lc4_fetch_buffer

Overview:
- Instruction-fetch stage directly upstream of the LC4 20-bit instruction decoder.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel with a valid-only response channel.
- Buffers returned instructions in a small FIFO and presents one instruction per cycle, with its PC, to decode under a valid/ready handshake.
- A redirect from execute (taken branch, JSR, RTI) flushes buffered and in-flight instructions and restarts fetch at the new PC.

Parameters:
- INSN_W, 20, instruction width; matches the decoder `insn` input.
- ADDR_W, 16, PC / instruction-memory address width.
- DEPTH, 2, FIFO entries and maximum outstanding memory requests; power of two, at least 2.
- RESET_PC, 16'h8200, PC loaded on reset.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_addr, output, ADDR_W, fetch address; equals current fetch PC.
- imem_req_ready, input, 1, memory accepts the request this cycle.
- imem_resp_valid, input, 1, one instruction returned, in request order.
- imem_resp_data, input, INSN_W, returned instruction.
- redirect_valid, input, 1, flush and restart fetch.
- redirect_pc, input, ADDR_W, new fetch PC.
- insn_valid, output, 1, head of FIFO valid for decode.
- insn, output, INSN_W, head instruction; drives decoder `insn`.
- insn_pc, output, ADDR_W, PC of head instruction.
- insn_ready, input, 1, decode consumes head this cycle.

Behaviour:
- Reset (async, any cycle, including mid-flush or with requests in flight):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0, insn_valid = 0, insn = 0, insn_pc = 0.
  - In-flight memory responses at reset are the memory side's responsibility; the block assumes none arrive after reset deasserts.
- Credit rule:
  - imem_req_valid = (count + outstanding < DEPTH) && !redirect_valid.
  - Request fires when imem_req_valid && imem_req_ready. On fire: outstanding +1, fetch_pc +1 (mod 2^ADDR_W; 16'hFFFF wraps to 0).
  - Each request records its PC in a DEPTH-entry PC queue; the response pairs with the oldest recorded PC.
- Response:
  - imem_resp_valid with drop_cnt == 0 pushes {data, pc} into the FIFO; outstanding −1.
  - Overflow is impossible by the credit rule.
  - Same-cycle push and pop are allowed; count is unchanged.
- Decode side:
  - insn_valid = (count != 0); insn and insn_pc come from the FIFO head, combinationally.
  - Pop on insn_valid && insn_ready.
  - insn and insn_pc are held stable while insn_valid && !insn_ready.
  - When empty, insn and insn_pc show the last-popped entry, or 0 after reset.
  - Latency: a response arriving in cycle N is visible at the output in cycle N+1.
- Redirect (cycle N):
  - FIFO cleared; fetch_pc = redirect_pc; the PC queue is cleared.
  - drop_cnt = outstanding minus any response arriving in cycle N; outstanding = 0.
  - No request issues in cycle N. A response in cycle N is discarded. A pop in cycle N is ignored.
  - From N+1, requests issue at redirect_pc while drop_cnt > 0.
  - Dropped responses decrement drop_cnt and are not pushed. Credit counts drop_cnt as outstanding.
  - A back-to-back redirect adds the new in-flight requests to drop_cnt.
- FSM (2 states):
  - RUN: drop_cnt == 0.
  - FLUSH: drop_cnt > 0.
  - RUN→FLUSH on redirect with in-flight requests. FLUSH→RUN when the last dropped response arrives. Redirect in FLUSH stays in FLUSH.
- Arithmetic:
  - count, outstanding and drop_cnt are clog2(DEPTH)+1 bits.
  - FIFO pointers are clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package lc4_pkg:
  - INSN_W and ADDR_W constants.
  - RESET_PC constant.
  - Fetch state encoding (FETCH_RUN, FETCH_FLUSH).
- Sub-module lc4_sync_fifo: parameterised width and depth, push/pop/clear, count, head data.
  - Instantiated twice: the instruction FIFO (INSN_W+ADDR_W) and the PC queue (ADDR_W).

Test Plan:
- Reset then memory always ready with 1-cycle responses, insn_ready=1:
  - First request at 8200, then 8201, 8202…
  - insn_valid first asserts 2 cycles after the first fire with insn_pc=8200; sustained 1 insn/cycle.
- insn_ready=0 for 5 cycles:
  - Exactly DEPTH requests issue, then imem_req_valid=0.
  - insn/insn_pc are held at 8200 throughout; on release, output continues in order with no loss.
- imem_req_ready toggling 1/0 with variable response delay (1–3 cycles): decode sees strictly consecutive PCs and correct data.
- Redirect to 0x0010 with 2 requests outstanding:
  - The 2 stale responses are discarded and the FIFO empties the next cycle.
  - First delivered insn_pc=0x0010, carrying the data returned for address 0x0010.
- Redirect in FLUSH (second redirect to 0x0040 before the stale responses return): only 0x0040-stream instructions reach decode.
- Wrap and async reset:
  - redirect_pc=16'hFFFF gives fetch order FFFF, 0000, 0001.
  - Asserting rst mid-cycle during FLUSH clears insn_valid and imem_req_valid immediately; fetch resumes at 8200.

Source files
------------

// File: rtl/lc4_pkg.sv
// Shared constants and fetch-state encoding for the LC4 front end.
package lc4_pkg;
  localparam int INSN_W = 20;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h8200;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FLUSH
  } fetch_state_e;
endpackage

// File: rtl/lc4_sync_fifo.sv
// Small synchronous FIFO with clear; head data is read combinationally.
module lc4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_headData
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: nothing reads it until an entry is pushed.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_count    = r_count;
  assign o_headData = r_mem[r_rdPtr];

endmodule

// File: rtl/lc4_fetch_buffer.sv
// LC4 fetch stage: owns the PC, issues credited memory requests, buffers
// returned instructions for decode and flushes on redirect.
module lc4_fetch_buffer
  import lc4_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INSN_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              insn_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = INSN_W + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_nextState;
  logic [ADDR_W-1:0] r_fetchPc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_dropCnt;
  logic [CNT_W-1:0]  w_outNext;
  logic [CNT_W-1:0]  w_dropNext;
  logic [CNT_W-1:0]  w_fifoCount;
  logic [CNT_W-1:0]  w_pcqCount;
  logic [CNT_W+1:0]  w_inUse;
  logic [ENT_W-1:0]  w_head;
  logic [ENT_W-1:0]  r_lastOut;
  logic [ADDR_W-1:0] w_respPc;
  logic              w_fire;
  logic              w_keepResp;
  logic              w_dropResp;
  logic              w_pop;

  // Responses still owed for flushed requests count against the credit too.
  assign w_inUse = (CNT_W+2)'(w_fifoCount) + (CNT_W+2)'(r_outstanding) + (CNT_W+2)'(r_dropCnt);
  assign imem_req_valid = !rst && !redirect_valid && (w_inUse < (CNT_W+2)'(DEPTH));
  assign imem_req_addr  = r_fetchPc;
  assign w_fire = imem_req_valid && imem_req_ready;

  assign w_dropResp = imem_resp_valid && (r_state == FETCH_FLUSH);
  assign w_keepResp = imem_resp_valid && (r_state == FETCH_RUN) && !redirect_valid
                      && (w_pcqCount != '0);

  assign insn_valid = (w_fifoCount != '0);
  assign w_pop = insn_valid && insn_ready && !redirect_valid;
  assign {insn, insn_pc} = insn_valid ? w_head : r_lastOut;

  always_comb begin
    w_outNext   = r_outstanding;
    w_dropNext  = r_dropCnt;
    w_nextState = r_state;
    if (redirect_valid) begin
      w_outNext  = '0;
      w_dropNext = r_dropCnt + r_outstanding - CNT_W'(imem_resp_valid);
    end else begin
      w_outNext = r_outstanding + CNT_W'(w_fire) - CNT_W'(w_keepResp);
      if (w_dropResp) w_dropNext = r_dropCnt - CNT_W'(1);
    end
    w_nextState = (w_dropNext != '0) ? FETCH_FLUSH : FETCH_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH_RUN;
      r_fetchPc     <= RESET_PC;
      r_outstanding <= '0;
      r_dropCnt     <= '0;
      r_lastOut     <= '0;
    end else begin
      r_state       <= w_nextState;
      r_outstanding <= w_outNext;
      r_dropCnt     <= w_dropNext;
      if (redirect_valid) r_fetchPc <= redirect_pc;
      else if (w_fire)    r_fetchPc <= r_fetchPc + ADDR_W'(1);
      if (w_pop) r_lastOut <= w_head;
    end
  end

  lc4_sync_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_insnFifo (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (redirect_valid),
    .i_push     (w_keepResp),
    .i_pushData ({imem_resp_data, w_respPc}),
    .i_pop      (w_pop),
    .o_count    (w_fifoCount),
    .o_headData (w_head)
  );

  // Request PCs in issue order; each kept response takes the oldest one.
  lc4_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pcQueue (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (redirect_valid),
    .i_push     (w_fire),
    .i_pushData (r_fetchPc),
    .i_pop      (w_keepResp),
    .o_count    (w_pcqCount),
    .o_headData (w_respPc)
  );

endmodule
